// File: rtl/mips_pkg.sv
// Shared MIPS datapath definitions: jump codes, instruction field positions
// and reset defaults.
package mips_pkg;

  typedef enum logic [1:0] {
    JMP_NONE = 2'b00,
    JMP_J    = 2'b01,
    JMP_JAL  = 2'b10,
    JMP_JR   = 2'b11
  } jump_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam logic [31:0] RESET_PC  = 32'h0000_0000;

  localparam int unsigned OPCODE_MSB  = 31;
  localparam int unsigned OPCODE_LSB  = 26;
  localparam int unsigned J_INDEX_MSB = 25;

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: instruction, PC+4 and valid flag.
// Flush has priority over enable so a squash is never lost under a stall.
module if_id_reg #(
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        flush,
  input  logic [31:0] instr_d,
  input  logic [31:0] pc4_d,
  output logic [31:0] instr_q,
  output logic [31:0] pc4_q,
  output logic        valid_q
);

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      instr_q <= NOP_INSTR;
      pc4_q   <= '0;
      valid_q <= 1'b0;
    end else if (en) begin
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= 1'b1;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, next-PC selection (EX branch, ID
// jump, stall, sequential) and the IF/ID pipeline register.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic [1:0]  jump,
  input  logic [31:0] jr_target,
  input  logic [31:0] imem_rdata,
  output logic [31:0] imem_addr,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc4,
  output logic        if_id_valid,
  output logic        flush_id
);
  import mips_pkg::*;

  logic [31:0] pc;
  logic [31:0] pc_next;
  logic [31:0] pc_plus4;
  logic [31:0] jump_target;
  jump_e       jump_eff;
  logic        ifid_en;
  logic        ifid_flush;
  logic        unused_bits;

  assign pc_plus4  = pc + 32'd4;
  assign imem_addr = pc;
  assign flush_id  = branch_taken & ~reset;

  // A jump code only means something when the ID slot holds a real instruction.
  assign jump_eff = if_id_valid ? jump_e'(jump) : JMP_NONE;

  always_comb begin
    jump_target = {if_id_pc4[31:28], if_id_instr[J_INDEX_MSB:0], 2'b00};
    if (jump_eff == JMP_JR)
      jump_target = {jr_target[31:2], 2'b00};
  end

  // Branch beats stall; stall holds a pending jump until its operand is safe.
  always_comb begin
    pc_next    = pc;
    ifid_en    = 1'b0;
    ifid_flush = 1'b0;
    if (branch_taken) begin
      pc_next    = {branch_target[31:2], 2'b00};
      ifid_flush = 1'b1;
    end else if (stall) begin
      pc_next = pc;
    end else if (jump_eff != JMP_NONE) begin
      pc_next    = jump_target;
      ifid_flush = 1'b1;
    end else begin
      pc_next = pc_plus4;
      ifid_en = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)
      pc <= {RESET_PC[31:2], 2'b00};
    else
      pc <= pc_next;
  end

  if_id_reg #(
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id (
    .clk     (clk),
    .reset   (reset),
    .en      (ifid_en),
    .flush   (ifid_flush),
    .instr_d (imem_rdata),
    .pc4_d   (pc_plus4),
    .instr_q (if_id_instr),
    .pc4_q   (if_id_pc4),
    .valid_q (if_id_valid)
  );

  assign unused_bits = ^{branch_target[1:0], jr_target[1:0],
                         if_id_instr[OPCODE_MSB:OPCODE_LSB], RESET_PC[1:0]};

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: reset, sequential fetch, stall, branch,
// jumps, PC wrap and mid-run reset.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic [1:0]  jump;
  logic [31:0] jr_target;
  logic [31:0] imem_rdata;
  logic [31:0] imem_addr;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc4;
  logic        if_id_valid;
  logic        flush_id;

  logic        use_fixed;
  logic [31:0] fixed_word;

  int unsigned total = 0;
  int unsigned passed = 0;

  always #5 clk = ~clk;

  // Instruction memory: address-tagged words unless a fixed word is forced.
  always_comb begin
    imem_rdata = use_fixed ? fixed_word : (imem_addr ^ 32'hA500_0000);
  end

  fetch_stage #(
    .RESET_PC  (32'h0000_0000),
    .NOP_INSTR (32'h0000_0000)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .jump          (jump),
    .jr_target     (jr_target),
    .imem_rdata    (imem_rdata),
    .imem_addr     (imem_addr),
    .if_id_instr   (if_id_instr),
    .if_id_pc4     (if_id_pc4),
    .if_id_valid   (if_id_valid),
    .flush_id      (flush_id)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; stall = 1'b0; branch_taken = 1'b1; branch_target = 32'h0000_0500;
    jump = 2'b00; jr_target = '0; use_fixed = 1'b0; fixed_word = '0;
    tick(); tick();
    total++;
    if (flush_id !== 1'b0) $display("FAIL reset_flush_id actual=%b required=0", flush_id);
    else passed++;
    branch_taken = 1'b0;
    total++;
    if (imem_addr !== 32'h0 || if_id_valid !== 1'b0 || if_id_instr !== 32'h0 || if_id_pc4 !== 32'h0)
      $display("FAIL reset_state actual=addr %h v %b i %h p4 %h required=0 0 0 0",
               imem_addr, if_id_valid, if_id_instr, if_id_pc4);
    else passed++;
    reset = 1'b0;
    #1;
    total++;
    if (imem_addr !== 32'h0) $display("FAIL release_addr actual=%h required=00000000", imem_addr);
    else passed++;
    tick();
    total++;
    if (if_id_valid !== 1'b1 || if_id_pc4 !== 32'h4 || if_id_instr !== 32'hA500_0000 || imem_addr !== 32'h4)
      $display("FAIL first_fetch actual=v %b p4 %h i %h addr %h required=1 00000004 a5000000 00000004",
               if_id_valid, if_id_pc4, if_id_instr, imem_addr);
    else passed++;
  endtask

  task automatic test_free_run();
    logic [31:0] exp_addr;
    exp_addr = 32'h4;
    for (int i = 0; i < 3; i++) begin
      tick();
      exp_addr = exp_addr + 32'd4;
      total++;
      if (imem_addr !== exp_addr || if_id_instr !== ((exp_addr - 32'd4) ^ 32'hA500_0000) ||
          if_id_pc4 !== exp_addr || if_id_valid !== 1'b1)
        $display("FAIL free_run[%0d] actual=addr %h i %h p4 %h required=addr %h i %h p4 %h",
                 i, imem_addr, if_id_instr, if_id_pc4, exp_addr,
                 (exp_addr - 32'd4) ^ 32'hA500_0000, exp_addr);
      else passed++;
    end
  endtask

  task automatic test_stall();
    total++;
    if (imem_addr !== 32'h10) $display("FAIL stall_start actual=%h required=00000010", imem_addr);
    else passed++;
    stall = 1'b1;
    jump = 2'b01;  // pending jump must wait while stalled
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (imem_addr !== 32'h10 || if_id_instr !== 32'hA500_000C || if_id_pc4 !== 32'h10 ||
          if_id_valid !== 1'b1 || flush_id !== 1'b0)
        $display("FAIL stall_hold[%0d] actual=addr %h i %h p4 %h v %b required=00000010 a500000c 00000010 1",
                 i, imem_addr, if_id_instr, if_id_pc4, if_id_valid);
      else passed++;
    end
    stall = 1'b0;
    jump = 2'b00;
    tick();
    total++;
    if (imem_addr !== 32'h14 || if_id_instr !== 32'hA500_0010 || if_id_pc4 !== 32'h14)
      $display("FAIL stall_resume actual=addr %h i %h p4 %h required=00000014 a5000010 00000014",
               imem_addr, if_id_instr, if_id_pc4);
    else passed++;
  endtask

  task automatic test_branch_over_stall();
    stall = 1'b1; branch_taken = 1'b1; branch_target = 32'h0000_0203; jump = 2'b11;
    jr_target = 32'h0000_9000;
    #1;
    total++;
    if (flush_id !== 1'b1) $display("FAIL branch_flush_id actual=%b required=1", flush_id);
    else passed++;
    tick();
    total++;
    if (imem_addr !== 32'h200 || if_id_valid !== 1'b0 || if_id_instr !== 32'h0 || if_id_pc4 !== 32'h0)
      $display("FAIL branch_redirect actual=addr %h v %b i %h p4 %h required=00000200 0 0 0",
               imem_addr, if_id_valid, if_id_instr, if_id_pc4);
    else passed++;
    stall = 1'b0; branch_taken = 1'b0; jump = 2'b01;
    #1;
    total++;
    if (flush_id !== 1'b0) $display("FAIL flush_id_clear actual=%b required=0", flush_id);
    else passed++;
    // Jump with an invalid IF/ID slot is ignored.
    tick();
    total++;
    if (imem_addr !== 32'h204 || if_id_valid !== 1'b1 || if_id_pc4 !== 32'h204)
      $display("FAIL jump_ignored actual=addr %h v %b p4 %h required=00000204 1 00000204",
               imem_addr, if_id_valid, if_id_pc4);
    else passed++;
    jump = 2'b00;
  endtask

  task automatic test_jump();
    branch_taken = 1'b1; branch_target = 32'h4000_0004;
    tick();
    branch_taken = 1'b0;
    use_fixed = 1'b1; fixed_word = 32'h0800_0010;
    tick();
    total++;
    if (if_id_pc4 !== 32'h4000_0008 || if_id_instr !== 32'h0800_0010 || if_id_valid !== 1'b1)
      $display("FAIL jump_setup actual=p4 %h i %h v %b required=40000008 08000010 1",
               if_id_pc4, if_id_instr, if_id_valid);
    else passed++;
    jump = 2'b01;
    tick();
    jump = 2'b00;
    total++;
    if (imem_addr !== 32'h4000_0040 || if_id_valid !== 1'b0 || if_id_instr !== 32'h0)
      $display("FAIL jump_j actual=addr %h v %b i %h required=40000040 0 0",
               imem_addr, if_id_valid, if_id_instr);
    else passed++;
    use_fixed = 1'b0;
  endtask

  task automatic test_wrap_and_jr();
    branch_taken = 1'b1; branch_target = 32'hFFFF_FFFE;
    tick();
    branch_taken = 1'b0;
    total++;
    if (imem_addr !== 32'hFFFF_FFFC) $display("FAIL wrap_setup actual=%h required=fffffffc", imem_addr);
    else passed++;
    tick();
    total++;
    if (imem_addr !== 32'h0 || if_id_pc4 !== 32'h0 || if_id_valid !== 1'b1 || if_id_instr !== 32'h5AFF_FFFC)
      $display("FAIL wrap actual=addr %h p4 %h v %b i %h required=00000000 00000000 1 5afffffc",
               imem_addr, if_id_pc4, if_id_valid, if_id_instr);
    else passed++;
    jump = 2'b11; jr_target = 32'h0000_1007;
    tick();
    jump = 2'b00;
    total++;
    if (imem_addr !== 32'h0000_1004 || if_id_valid !== 1'b0)
      $display("FAIL jr actual=addr %h v %b required=00001004 0", imem_addr, if_id_valid);
    else passed++;
  endtask

  task automatic test_jal_and_midrun_reset();
    tick();
    total++;
    if (imem_addr !== 32'h1008 || if_id_pc4 !== 32'h1008)
      $display("FAIL post_jr_fetch actual=addr %h p4 %h required=00001008 00001008", imem_addr, if_id_pc4);
    else passed++;
    // instr tagged 0x1004^A5000000 = A5001004, index 26'h1001004 -> target {0,1001004,00}
    jump = 2'b10;
    tick();
    jump = 2'b00;
    total++;
    if (imem_addr !== 32'h0400_4010 || if_id_valid !== 1'b0)
      $display("FAIL jal actual=addr %h v %b required=04004010 0", imem_addr, if_id_valid);
    else passed++;
    tick(); tick();
    reset = 1'b1; branch_taken = 1'b1; branch_target = 32'h0000_0300;
    #1;
    total++;
    if (flush_id !== 1'b0) $display("FAIL midrun_flush_id actual=%b required=0", flush_id);
    else passed++;
    tick();
    reset = 1'b0; branch_taken = 1'b0;
    total++;
    if (imem_addr !== 32'h0 || if_id_valid !== 1'b0 || if_id_instr !== 32'h0 || if_id_pc4 !== 32'h0)
      $display("FAIL midrun_reset actual=addr %h v %b i %h p4 %h required=0 0 0 0",
               imem_addr, if_id_valid, if_id_instr, if_id_pc4);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_stall();
    test_branch_over_stall();
    test_jump();
    test_wrap_and_jr();
    test_jal_and_midrun_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
